// File: rtl/multicyc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding word fetch at a
// time to a variable-latency memory, and loads the IF/ID pipeline register.
module multicyc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h004000a8,
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic        iClk,
  input  logic        iRst_n,
  output logic        oImemReq,
  output logic [31:0] oImemAddr,
  input  logic        iImemValid,
  input  logic [31:0] iImemData,
  input  logic        iStall,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  input  logic        _iPCLoad,
  input  logic [31:0] _iPCLoadData,
  output logic        oIFID_Valid,
  output logic [31:0] oIFID_Inst,
  output logic [31:0] oIFID_PCAddFour,
  output logic [31:0] _oPC
);

  typedef enum logic [1:0] {S_WAIT, S_HOLD, S_DROP} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc4;
  } ifid_t;

  localparam ifid_t IFID_FLUSH = '{valid: 1'b0, inst: NOP_INST, pc4: 32'h0};

  state_t      state, state_n;
  logic [31:0] pc, pc_n, addr, addr_n;
  ifid_t       ifid, ifid_n, hold_buf, hold_buf_n;
  logic        redir;
  logic [31:0] target, pc_plus4;

  assign redir    = _iPCLoad | iRedirect;
  assign target   = (_iPCLoad ? _iPCLoadData : iRedirectPC) & 32'hFFFF_FFFC;
  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge iClk) begin
    if (!iRst_n) state <= S_WAIT;
    else         state <= state_n;
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      pc       <= RESET_PC;
      addr     <= RESET_PC;
      ifid     <= IFID_FLUSH;
      hold_buf <= '0;
    end else begin
      pc       <= pc_n;
      addr     <= addr_n;
      ifid     <= ifid_n;
      hold_buf <= hold_buf_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    addr_n     = addr;
    ifid_n     = ifid;
    hold_buf_n = hold_buf;
    case (state)
      S_WAIT: begin
        if (redir) begin
          pc_n   = target;
          ifid_n = IFID_FLUSH;
          // A response landing with the redirect is consumed and dropped, so
          // the target can be requested next cycle; otherwise wait it out.
          if (iImemValid) addr_n  = target;
          else            state_n = S_DROP;
        end else if (iImemValid) begin
          if (iStall) begin
            hold_buf_n = '{valid: 1'b1, inst: iImemData, pc4: pc_plus4};
            state_n    = S_HOLD;
          end else begin
            ifid_n = '{valid: 1'b1, inst: iImemData, pc4: pc_plus4};
            pc_n   = pc_plus4;
            addr_n = pc_plus4;
          end
        end else if (!iStall) begin
          ifid_n = IFID_FLUSH;
        end
      end
      S_HOLD: begin
        if (redir) begin
          pc_n    = target;
          addr_n  = target;
          ifid_n  = IFID_FLUSH;
          state_n = S_WAIT;
        end else if (!iStall) begin
          ifid_n  = hold_buf;
          pc_n    = pc_plus4;
          addr_n  = pc_plus4;
          state_n = S_WAIT;
        end
      end
      S_DROP: begin
        ifid_n = IFID_FLUSH;
        if (redir) pc_n = target;
        if (iImemValid) begin
          addr_n  = redir ? target : pc;
          state_n = S_WAIT;
        end
      end
      default: state_n = S_WAIT;
    endcase
  end

  assign oImemReq        = iRst_n & (state != S_HOLD);
  assign oImemAddr       = addr;
  assign oIFID_Valid     = ifid.valid;
  assign oIFID_Inst      = ifid.inst;
  assign oIFID_PCAddFour = ifid.pc4;
  assign _oPC            = pc;

endmodule
